// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: IF/ID instruction buffer, DEPTH-entry circular queue of {pc, instr}.
// Ports: fetch side (in_valid/in_ready/in_pc/in_instr), decode side (out_valid/out_ready,
//   out_pc/out_instr plus pre-split opcode/funct3/funct7/rd/rs1/rs2), flush, count.
//   rst is asynchronous and active-low.
// Optional: define IFQ_BYPASS_EN for a same-cycle empty-queue bypass from in_* to out_*.
module ifid_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instr,
    output logic [6:0]             out_opcode,
    output logic [2:0]             out_funct3,
    output logic [6:0]             out_funct7,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic            store_valid;
    logic            bypass;
    logic            enq;
    logic            deq;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;

    assign store_valid = (count_q != '0);
    assign in_ready    = (count_q != CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
    // Empty queue hands the incoming instruction straight to decode.
    assign bypass = !store_valid && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction taken by decode is never written.
    assign enq = in_valid && in_ready && !(bypass && out_ready);
    assign deq = store_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
        end
    end

    assign head_pc    = bypass ? in_pc    : pc_mem_q[head_q];
    assign head_instr = bypass ? in_instr : instr_mem_q[head_q];

    assign out_valid = store_valid || bypass;
    // Empty queue presents a NOP at PC 0 so decode never sees stale data.
    assign out_pc    = out_valid ? head_pc    : '0;
    assign out_instr = out_valid ? head_instr : NOP;

    assign out_opcode = out_instr[6:0];
    assign out_rd     = out_instr[11:7];
    assign out_funct3 = out_instr[14:12];
    assign out_rs1    = out_instr[19:15];
    assign out_rs2    = out_instr[24:20];
    assign out_funct7 = out_instr[31:25];
    assign count      = count_q;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb_ifid_fetch_queue: directed scenarios plus randomized traffic for ifid_fetch_queue,
// checked against a queue-based reference model of the instruction buffer.
module tb_ifid_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_instr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [CW-1:0]   count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO of {pc, instr}.
    logic [63:0] mq[$];

    ifid_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Drive one cycle (called just after a negedge), advance the model
    // at the rising edge, return at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy,
                         input logic fl);
        bit can_in;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            can_in = (mq.size() < DEPTH);
            if (ordy && mq.size() > 0) void'(mq.pop_front());
            if (v && can_in) mq.push_back({pc, ins});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mq.delete();
        @(negedge clk);
        n_cmp++;
        if (count !== '0) begin
            n_bad++; $display("FAIL reset_count got %0d want 0", count);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_instr !== 32'h0000_0013) begin
            n_bad++; $display("FAIL reset_nop got %h want 00000013", out_instr);
        end
        n_cmp++;
        if (out_pc !== '0) begin
            n_bad++; $display("FAIL reset_pc got %h want 0", out_pc);
        end
    endtask

    task automatic test_single;
        cycle(1'b1, 32'h60, 32'h00A0_8093, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || count !== CW'(1)) begin
            n_bad++;
            $display("FAIL single_valid got v=%b c=%0d want v=1 c=1", out_valid, count);
        end
        n_cmp++;
        if (out_pc !== 32'h60 || out_instr !== 32'h00A0_8093) begin
            n_bad++;
            $display("FAIL single_head got %h/%h want 60/00a08093", out_pc, out_instr);
        end
        n_cmp++;
        if (out_opcode !== 7'h13 || out_funct3 !== 3'd0 || out_rd !== 5'd1
            || out_rs1 !== 5'd1 || out_rs2 !== 5'd10 || out_funct7 !== 7'd0) begin
            n_bad++;
            $display("FAIL single_fields got op=%h f3=%0d rd=%0d rs1=%0d rs2=%0d f7=%0d want 13/0/1/1/10/0",
                     out_opcode, out_funct3, out_rd, out_rs1, out_rs2, out_funct7);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain got c=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h60 + 32'(4 * i), 32'h0000_0013 | 32'(i << 7), 1'b0, 1'b0);
            if (i == 3) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++; $display("FAIL fill_in_ready got %b want 0", in_ready);
                end
            end
        end
        n_cmp++;
        if (count !== CW'(4)) begin
            n_bad++; $display("FAIL fill_count got %0d want 4", count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'h60 + 32'(4 * i)) begin
                n_bad++;
                $display("FAIL fill_order[%0d] got v=%b pc=%h want pc=%h",
                         i, out_valid, out_pc, 32'h60 + 32'(4 * i));
            end
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || count !== '0) begin
            n_bad++;
            $display("FAIL fill_empty got v=%b c=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] pc;
        logic [31:0] prev;
        pc = 32'h100;
        repeat (2) begin
            cycle(1'b1, pc, 32'h0000_0013, 1'b0, 1'b0);
            pc += 4;
        end
        prev = out_pc;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, pc, 32'h0000_0013, 1'b1, 1'b0);
            pc += 4;
            n_cmp++;
            if (count !== CW'(2) || out_pc !== prev + 32'd4) begin
                n_bad++;
                $display("FAIL wrap[%0d] got c=%0d pc=%h want c=2 pc=%h",
                         i, count, out_pc, prev + 32'd4);
            end
            prev = prev + 32'd4;
        end
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (count !== '0) begin
            n_bad++; $display("FAIL wrap_drain got %0d want 0", count);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h800 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
        n_cmp++;
        if (count !== CW'(3)) begin
            n_bad++; $display("FAIL flush_pre got %0d want 3", count);
        end
        cycle(1'b1, 32'h900, 32'h0010_0093, 1'b1, 1'b1);
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_clear got c=%0d v=%b want 0/0", count, out_valid);
        end
        repeat (3) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || out_pc === 32'h900) begin
                n_bad++;
                $display("FAIL flush_leak got v=%b pc=%h want v=0", out_valid, out_pc);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hA00 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        mq.delete();
        #1;
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got c=%0d v=%b want 0/0", count, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'hB00, 32'h0020_8113, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'hB00 || count !== CW'(1)) begin
            n_bad++;
            $display("FAIL async_after got v=%b pc=%h c=%0d want 1/b00/1",
                     out_valid, out_pc, count);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] epc;
        logic [31:0] ein;
        for (int i = 0; i < 400; i++) begin
            epc = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            ein = (mq.size() > 0) ? mq[0][31:0]  : 32'h0000_0013;
            n_cmp++;
            if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0)
                || in_ready !== (mq.size() != DEPTH)) begin
                n_bad++;
                $display("FAIL rand_state[%0d] got c=%0d v=%b r=%b want c=%0d",
                         i, count, out_valid, in_ready, mq.size());
            end
            n_cmp++;
            if (out_pc !== epc || out_instr !== ein || out_rs2 !== ein[24:20]
                || out_funct7 !== ein[31:25]) begin
                n_bad++;
                $display("FAIL rand_head[%0d] got %h/%h want %h/%h",
                         i, out_pc, out_instr, epc, ein);
            end
            cycle($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC, $urandom(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifid_fetch_queue.md
Name: ifid_fetch_queue

Overview:
Instruction buffer between the instruction-cache response and the decode stage. It absorbs fetch/decode rate mismatch and pipeline stalls. It presents the head instruction pre-split into opcode/funct3/funct7/register fields, which feed the decode control ROM. On a redirect (taken branch or jump resolved in EX), it discards all buffered instructions in one cycle.

Parameters:
DEPTH, 4, number of instruction entries; power of 2, minimum 2
XLEN, 32, width of PC and instruction words

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous and active-low (asserted when 0)
flush  in  1  synchronous discard of all entries (redirect from EX)
in_valid  in  1  fetch side has an instruction this cycle
in_ready  out  1  queue can accept an instruction this cycle
in_pc  in  XLEN  PC of the incoming instruction
in_instr  in  XLEN  incoming instruction word
out_valid  out  1  head entry is valid
out_ready  in  1  decode consumes the head this cycle (deasserted on stall)
out_pc  out  XLEN  PC of the head entry
out_instr  out  XLEN  head instruction word
out_opcode  out  7  out_instr[6:0]
out_funct3  out  3  out_instr[14:12]
out_funct7  out  7  out_instr[31:25]
out_rd  out  5  out_instr[11:7]
out_rs1  out  5  out_instr[19:15]
out_rs2  out  5  out_instr[24:20]
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular buffer of DEPTH {pc, instr} entries, with head and tail pointers of $clog2(DEPTH) bits and a separate count register.
- Pointers wrap modulo DEPTH naturally (power-of-2 depth).
- Reset (rst=0, asynchronous): head=0, tail=0, count=0, so out_valid=0.
- Reset value of storage is don't-care. When out_valid=0, out_instr is forced to 32'h00000013 (addi x0,x0,0) and out_pc to 0. Decode therefore always sees a NOP when the queue is empty.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so a full queue does not accept even if a dequeue happens the same cycle.
- out_valid = (count != 0).
- Enqueue fires when in_valid & in_ready: write entry[tail], tail+1.
- Dequeue fires when out_valid & out_ready: head+1.
- Count update:
  - enqueue only: count+1
  - dequeue only: count-1
  - both: count unchanged
  - neither: hold
- Latency: an instruction enqueued at edge N is visible on out_* after edge N, i.e. one cycle of latency (see optional feature).
- Output fields are combinational slices of the registered head entry; there is no extra pipeline stage.
- flush=1 at an edge: head=tail=0, count=0.
  - Any enqueue and dequeue in that same cycle are discarded.
  - out_valid=0 in the following cycle.
  - flush has priority over all other events.
- flush while empty: no effect besides pointer reset.
- in_valid while full: no write; the fetch side must hold in_pc/in_instr until in_ready.
- out_ready while empty: ignored; count never underflows.
- Reset asserted mid-operation: all contents lost immediately; no partial update on the release edge.

Optional Feature:
IFQ_BYPASS_EN.
- Defined: when count==0 and in_valid=1 and flush=0, out_valid=1 combinationally and out_* present in_pc/in_instr in the same cycle.
  - If out_ready=1, the instruction is consumed without being written and count stays 0.
  - If out_ready=0, it is written normally.
- Undefined: no bypass. Minimum latency is 1 cycle and there is no in_* to out_* combinational path.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then 1 -> count=0, out_valid=0, in_ready=1, out_instr=0x00000013, out_pc=0.
2. Single instruction: enqueue pc=0x60, instr=0x00A08093 (addi x1,x1,10) with out_ready=0 -> next cycle out_valid=1, out_opcode=0x13, out_funct3=0, out_rd=1, out_rs1=1, count=1; assert out_ready -> count=0.
3. Fill/full: out_ready=0, enqueue 5 instructions pc=0x60..0x70 -> count=4, in_ready=0 after the 4th, the 5th is not written; drain -> PCs emerge 0x60,0x64,0x68,0x6C in order.
4. Wrap and simultaneous: hold count=2, then enqueue and dequeue every cycle for 10 cycles -> count stays 2, output PC sequence is strictly +4, pointers wrap past DEPTH-1 with no loss.
5. Flush with concurrent traffic: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the flushed-cycle input is never output.
6. Async reset mid-stream: count=3, drop rst between clock edges -> count=0 and out_valid=0 immediately, without waiting for a clock edge; after release, the first new enqueue appears with the correct PC.
